// File: rtl/axi_axil_adapter_rd_if.sv
// Read-channel bundles for axi_axil_adapter_rd: a full AXI4 read channel and an AXI4-Lite one.
interface axi_rd_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

interface axil_rd_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_axil_adapter_rd.sv
// Read-only AXI4 to AXI4-Lite bridge: splits each AXI beat into lite reads, keeps up to
// MAX_OUTSTANDING lite reads in flight and reassembles the returned words into AXI beats.
module axi_axil_adapter_rd #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_ID_WIDTH    = 8,
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    axi_rd_if.slave   s_axi,
    axil_rd_if.master m_axil
);
    localparam int unsigned W         = AXIL_DATA_WIDTH / 8;
    localparam int unsigned B         = AXI_DATA_WIDTH / 8;
    localparam int unsigned WL        = $clog2(W);
    localparam int unsigned BL        = $clog2(B);
    localparam int unsigned SEGS      = B / W;
    localparam int unsigned SEG_WIDTH = $clog2(SEGS) + 1;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    // First lite address of a beat: aligned to the larger of the beat size and the lite width.
    function automatic addr_t seg_base(input addr_t a, input logic [2:0] sz);
        addr_t mask;
        mask = (sz > 3'(WL)) ? (addr_t'(1) << sz) - addr_t'(1) : addr_t'(W - 1);
        return a & ~mask;
    endfunction

    function automatic addr_t next_beat(input addr_t a, input logic [7:0] len,
                                        input logic [2:0] sz, input logic [1:0] bt);
        addr_t step, win, r;
        step = addr_t'(1) << sz;
        win  = (addr_t'(len) + addr_t'(1)) << sz;
        case (bt)
            2'd0:    r = a;
            2'd2:    r = (a & ~(win - addr_t'(1))) | ((a + step) & (win - addr_t'(1)));
            default: r = a + step;
        endcase
        return r;
    endfunction

    state_e                      state_q;
    logic [AXI_ID_WIDTH-1:0]     id_q;
    logic [7:0]                  len_q;
    logic [2:0]                  size_q;
    logic [1:0]                  burst_q;
    logic [2:0]                  prot_q;
    logic [SEG_WIDTH-1:0]        last_seg_q;
    logic                        arready_q;

    logic                        ar_valid_q;
    addr_t                       ar_addr_q;
    logic [7:0]                  iss_beat_q;
    logic [SEG_WIDTH-1:0]        iss_seg_q;
    addr_t                       iss_addr_q;
    logic                        iss_done_q;

    logic [7:0]                  col_beat_q;
    logic [SEG_WIDTH-1:0]        col_seg_q;
    addr_t                       col_addr_q;
    addr_t                       col_lite_q;
    logic [AXI_DATA_WIDTH-1:0]   buf_q;
    logic [1:0]                  resp_acc_q;
    logic [CNT_WIDTH-1:0]        cnt_q;

    logic                        rvalid_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                  rresp_q;
    logic [AXI_ID_WIDTH-1:0]     rid_q;
    logic                        rlast_q;

    logic                        ar_hs, lite_ar_hs, lite_r_hs, r_hs, lite_rready;
    logic [2:0]                  ar_size;
    logic [SEG_WIDTH-1:0]        ar_last_seg;
    logic                        iss_last, iss_done_d, ar_valid_d;
    logic [CNT_WIDTH-1:0]        cnt_d;
    addr_t                       iss_next, col_next, lane_idx;
    logic [AXI_DATA_WIDTH-1:0]   buf_d;
    logic [1:0]                  resp_d;

    assign ar_hs       = s_axi.arvalid && arready_q;
    assign lite_ar_hs  = ar_valid_q && m_axil.arready;
    assign lite_rready = (state_q == StBurst) && (!rvalid_q || s_axi.rready);
    assign lite_r_hs   = m_axil.rvalid && lite_rready;
    assign r_hs        = rvalid_q && s_axi.rready;

    assign ar_size     = (s_axi.arsize > 3'(BL)) ? 3'(BL) : s_axi.arsize;
    assign ar_last_seg = (ar_size > 3'(WL)) ?
                         SEG_WIDTH'((32'd1 << (ar_size - 3'(WL))) - 32'd1) : '0;

    assign iss_last = (iss_seg_q == last_seg_q) && (iss_beat_q == len_q);
    assign iss_next = next_beat(iss_addr_q, len_q, size_q, burst_q);
    assign col_next = next_beat(col_addr_q, len_q, size_q, burst_q);
    assign lane_idx = (col_lite_q >> WL) & addr_t'(SEGS - 1);

    always_comb begin
        cnt_d = cnt_q;
        if (lite_ar_hs && !lite_r_hs) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!lite_ar_hs && lite_r_hs) begin
            cnt_d = cnt_q - 1'b1;
        end
        iss_done_d = iss_done_q;
        if (ar_hs) begin
            iss_done_d = 1'b0;
        end else if (lite_ar_hs && iss_last) begin
            iss_done_d = 1'b1;
        end
    end

    // Once raised, arvalid cannot fall before its handshake: the count never rises meanwhile.
    assign ar_valid_d = ((state_q == StBurst) || ar_hs) && !iss_done_d &&
                        (cnt_d < CNT_WIDTH'(MAX_OUTSTANDING));

    always_comb begin
        buf_d = (col_seg_q == '0) ? '0 : buf_q;
        for (int i = 0; i < int'(SEGS); i++) begin
            if (lane_idx == addr_t'(i)) begin
                buf_d[i*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH] = m_axil.rdata;
            end
        end
        resp_d = (col_seg_q == '0 || m_axil.rresp > resp_acc_q) ? m_axil.rresp : resp_acc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            prot_q     <= '0;
            last_seg_q <= '0;
            arready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            iss_beat_q <= '0;
            iss_seg_q  <= '0;
            iss_addr_q <= '0;
            iss_done_q <= 1'b1;
            col_beat_q <= '0;
            col_seg_q  <= '0;
            col_addr_q <= '0;
            col_lite_q <= '0;
            buf_q      <= '0;
            resp_acc_q <= '0;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rid_q      <= '0;
            rlast_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ar_valid_q <= ar_valid_d;
            iss_done_q <= iss_done_d;
            case (state_q)
                StIdle: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        state_q    <= StBurst;
                        arready_q  <= 1'b0;
                        id_q       <= s_axi.arid;
                        len_q      <= s_axi.arlen;
                        size_q     <= ar_size;
                        burst_q    <= s_axi.arburst;
                        prot_q     <= s_axi.arprot;
                        last_seg_q <= ar_last_seg;
                        iss_beat_q <= '0;
                        iss_seg_q  <= '0;
                        iss_addr_q <= s_axi.araddr;
                        ar_addr_q  <= seg_base(s_axi.araddr, ar_size);
                        col_beat_q <= '0;
                        col_seg_q  <= '0;
                        col_addr_q <= s_axi.araddr;
                        col_lite_q <= seg_base(s_axi.araddr, ar_size);
                    end
                end
                StBurst: begin
                    if (lite_ar_hs) begin
                        if (iss_seg_q == last_seg_q) begin
                            iss_seg_q  <= '0;
                            iss_beat_q <= iss_beat_q + 8'd1;
                            iss_addr_q <= iss_next;
                            ar_addr_q  <= seg_base(iss_next, size_q);
                        end else begin
                            iss_seg_q <= iss_seg_q + 1'b1;
                            ar_addr_q <= ar_addr_q + addr_t'(W);
                        end
                    end
                    if (r_hs) begin
                        rvalid_q <= 1'b0;
                    end
                    if (lite_r_hs) begin
                        buf_q      <= buf_d;
                        resp_acc_q <= resp_d;
                        if (col_seg_q == last_seg_q) begin
                            col_seg_q  <= '0;
                            col_beat_q <= col_beat_q + 8'd1;
                            col_addr_q <= col_next;
                            col_lite_q <= seg_base(col_next, size_q);
                            rvalid_q   <= 1'b1;
                            rdata_q    <= buf_d;
                            rresp_q    <= resp_d;
                            rid_q      <= id_q;
                            rlast_q    <= (col_beat_q == len_q);
                        end else begin
                            col_seg_q  <= col_seg_q + 1'b1;
                            col_lite_q <= col_lite_q + addr_t'(W);
                        end
                    end
                    if (r_hs && rlast_q) begin
                        state_q   <= StIdle;
                        arready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_axi.arready  = arready_q;
    assign s_axi.rvalid   = rvalid_q;
    assign s_axi.rdata    = rdata_q;
    assign s_axi.rresp    = rresp_q;
    assign s_axi.rid      = rid_q;
    assign s_axi.rlast    = rlast_q;
    assign m_axil.arvalid = ar_valid_q;
    assign m_axil.araddr  = ar_addr_q;
    assign m_axil.arprot  = prot_q;
    assign m_axil.rready  = lite_rready;
endmodule

// File: tb/tb_axi_axil_adapter_rd.sv
// Bench for axi_axil_adapter_rd: directed bursts against a latency-modelled lite slave,
// with expected lite addresses and AXI beats checked by scoreboard monitors.
module tb_axi_axil_adapter_rd;
    logic clk = 1'b0;
    logic rst_n;

    initial forever #5 clk = ~clk;

    axi_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(8)) s_axi ();
    axil_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axil ();

    axi_axil_adapter_rd #(
        .ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(8),
        .AXIL_DATA_WIDTH(32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axi(s_axi),
        .m_axil(m_axil)
    );

    typedef struct {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    beat_t       exp_r[$];
    logic [31:0] exp_lite[$];
    pend_t       pending[$];
    logic [1:0]  resp_map[logic [31:0]];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         lat = 2;
    int         out_cnt = 0;
    int         max_out = 0;
    logic [2:0] cur_prot = 3'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [7:0] id, input logic [63:0] data,
                             input logic [1:0] resp, input logic last);
        beat_t b;
        b.id = id;
        b.data = data;
        b.resp = resp;
        b.last = last;
        exp_r.push_back(b);
    endtask

    task automatic push_lite_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_lite.push_back(start + 32'(4 * i));
    endtask

    task automatic issue_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [2:0] prot);
        int n = 0;
        cur_prot = prot;
        s_axi.arid = id;
        s_axi.araddr = addr;
        s_axi.arlen = len;
        s_axi.arsize = size;
        s_axi.arburst = burst;
        s_axi.arprot = prot;
        s_axi.arvalid = 1'b1;
        @(negedge clk);
        while (!s_axi.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi.arready) begin
            checks++;
            errors++;
            $display("FAIL ar_handshake_timeout: got arready=0, required 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        s_axi.arvalid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_r.size() != 0 || exp_lite.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_r.size() != 0 || exp_lite.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d beats and %0d lite reads pending, required 0",
                     name, exp_r.size(), exp_lite.size());
            exp_r.delete();
            exp_lite.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats_left(input int left);
        int n = 0;
        while (exp_r.size() > left && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_r.size() > left) begin
            checks++;
            errors++;
            $display("FAIL beat_progress_timeout: got %0d beats pending, required %0d",
                     exp_r.size(), left);
        end
    endtask

    task automatic check_reset_values();
        check("rst_arready", 64'(s_axi.arready), 64'd0);
        check("rst_rvalid", 64'(s_axi.rvalid), 64'd0);
        check("rst_rlast", 64'(s_axi.rlast), 64'd0);
        check("rst_rdata", s_axi.rdata, 64'd0);
        check("rst_rresp", 64'(s_axi.rresp), 64'd0);
        check("rst_rid", 64'(s_axi.rid), 64'd0);
        check("rst_lite_arvalid", 64'(m_axil.arvalid), 64'd0);
        check("rst_lite_araddr", 64'(m_axil.araddr), 64'd0);
        check("rst_lite_arprot", 64'(m_axil.arprot), 64'd0);
        check("rst_lite_rready", 64'(m_axil.rready), 64'd0);
    endtask

    // AXI R monitor
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && s_axi.rvalid && s_axi.rready) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got beat data 0x%0h, required no beat", s_axi.rdata);
                end else begin
                    b = exp_r.pop_front();
                    check("rdata", s_axi.rdata, b.data);
                    check("rresp", 64'(s_axi.rresp), 64'(b.resp));
                    check("rid", 64'(s_axi.rid), 64'(b.id));
                    check("rlast", 64'(s_axi.rlast), 64'(b.last));
                end
            end
        end
    end

    // Lite slave: accepts every AR, tracks in-flight reads, returns them in order after lat
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending.delete();
                out_cnt = 0;
            end else begin
                if (m_axil.arvalid && m_axil.arready) begin
                    if (exp_lite.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lite_ar_unexpected: got addr 0x%0h, required none",
                                 m_axil.araddr);
                    end else begin
                        check("lite_araddr", 64'(m_axil.araddr), 64'(exp_lite.pop_front()));
                    end
                    check("lite_arprot", 64'(m_axil.arprot), 64'(cur_prot));
                    p.addr = m_axil.araddr;
                    p.due = cyc + lat;
                    pending.push_back(p);
                    out_cnt++;
                end
                if (m_axil.rvalid && m_axil.rready) begin
                    void'(pending.pop_front());
                    out_cnt--;
                end
                if (out_cnt > max_out) max_out = out_cnt;
            end
        end
    end

    initial begin
        logic [31:0] a;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && pending.size() > 0 && pending[0].due <= cyc) begin
                a = pending[0].addr;
                m_axil.rvalid = 1'b1;
                m_axil.rdata = a ^ 32'hA5A5_0000;
                m_axil.rresp = resp_map.exists(a) ? resp_map[a] : 2'd0;
            end else begin
                m_axil.rvalid = 1'b0;
                m_axil.rdata = 32'd0;
                m_axil.rresp = 2'd0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        s_axi.arvalid = 1'b0;
        s_axi.arid = '0;
        s_axi.araddr = '0;
        s_axi.arlen = '0;
        s_axi.arsize = '0;
        s_axi.arburst = '0;
        s_axi.arprot = '0;
        s_axi.rready = 1'b1;
        m_axil.arready = 1'b1;
        m_axil.rvalid = 1'b0;
        m_axil.rdata = '0;
        m_axil.rresp = '0;
        resp_map[32'h4004] = 2'd2;
        resp_map[32'h5000] = 2'd3;
        resp_map[32'h5004] = 2'd2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("arready_before_rise", 64'(s_axi.arready), 64'd0);
        @(posedge clk);
        #1;
        check("arready_after_reset", 64'(s_axi.arready), 64'd1);

        // 64-to-32 INCR burst
        push_lite_run(32'h1000, 8);
        push_beat(8'h3C, 64'hA5A51004_A5A51000, 2'd0, 1'b0);
        push_beat(8'h3C, 64'hA5A5100C_A5A51008, 2'd0, 1'b0);
        push_beat(8'h3C, 64'hA5A51014_A5A51010, 2'd0, 1'b0);
        push_beat(8'h3C, 64'hA5A5101C_A5A51018, 2'd0, 1'b1);
        issue_ar(8'h3C, 32'h1000, 8'd3, 3'd3, 2'd1, 3'b010);
        check("first_lite_arvalid", 64'(m_axil.arvalid), 64'd1);
        check("arready_busy", 64'(s_axi.arready), 64'd0);
        wait_done("incr", 200);
        check("arready_idle_again", 64'(s_axi.arready), 64'd1);

        // Narrow INCR: 32-bit beats land in alternating halves
        push_lite_run(32'h2004, 2);
        push_beat(8'h11, 64'hA5A52004_00000000, 2'd0, 1'b0);
        push_beat(8'h11, 64'h00000000_A5A52008, 2'd0, 1'b1);
        issue_ar(8'h11, 32'h2004, 8'd1, 3'd2, 2'd1, 3'd0);
        wait_done("narrow", 200);

        // WRAP: 0x3018, 0x3000, 0x3008, 0x3010
        exp_lite.push_back(32'h3018);
        exp_lite.push_back(32'h301C);
        push_lite_run(32'h3000, 6);
        push_beat(8'h22, 64'hA5A5301C_A5A53018, 2'd0, 1'b0);
        push_beat(8'h22, 64'hA5A53004_A5A53000, 2'd0, 1'b0);
        push_beat(8'h22, 64'hA5A5300C_A5A53008, 2'd0, 1'b0);
        push_beat(8'h22, 64'hA5A53014_A5A53010, 2'd0, 1'b1);
        issue_ar(8'h22, 32'h3018, 8'd3, 3'd3, 2'd2, 3'd0);
        wait_done("wrap", 200);

        // FIXED: three beats all at 0x3100
        for (int i = 0; i < 3; i++) begin
            push_lite_run(32'h3100, 2);
            push_beat(8'h33, 64'hA5A53104_A5A53100, 2'd0, i == 2);
        end
        issue_ar(8'h33, 32'h3100, 8'd2, 3'd3, 2'd0, 3'd1);
        wait_done("fixed", 200);

        // Six-cycle slave latency: in-flight reads must cap at four
        lat = 6;
        max_out = 0;
        push_lite_run(32'h6000, 16);
        for (int i = 0; i < 8; i++) begin
            push_beat(8'h44, {32'hA5A56004 + 32'(8 * i), 32'hA5A56000 + 32'(8 * i)}, 2'd0, i == 7);
        end
        issue_ar(8'h44, 32'h6000, 8'd7, 3'd3, 2'd1, 3'd0);
        wait_done("latency", 400);
        check("max_outstanding", 64'(max_out), 64'd4);
        lat = 2;

        // Response merging: OKAY+SLVERR -> SLVERR, DECERR+SLVERR -> DECERR
        push_lite_run(32'h4000, 2);
        push_beat(8'h55, 64'hA5A54004_A5A54000, 2'd2, 1'b1);
        issue_ar(8'h55, 32'h4000, 8'd0, 3'd3, 2'd1, 3'd0);
        wait_done("slverr", 100);
        push_lite_run(32'h5000, 2);
        push_beat(8'h56, 64'hA5A55004_A5A55000, 2'd3, 1'b1);
        issue_ar(8'h56, 32'h5000, 8'd0, 3'd3, 2'd1, 3'd0);
        wait_done("decerr", 100);

        // rready stalled ten cycles mid-burst
        push_lite_run(32'h7000, 8);
        for (int i = 0; i < 4; i++) begin
            push_beat(8'h66, {32'hA5A57004 + 32'(8 * i), 32'hA5A57000 + 32'(8 * i)}, 2'd0, i == 3);
        end
        issue_ar(8'h66, 32'h7000, 8'd3, 3'd3, 2'd1, 3'd0);
        wait_beats_left(3);
        s_axi.rready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rvalid_held_in_stall", 64'(s_axi.rvalid), 64'd1);
        s_axi.rready = 1'b1;
        wait_done("stall", 200);

        // Reset pulsed mid-burst
        push_lite_run(32'h8000, 16);
        for (int i = 0; i < 8; i++) begin
            push_beat(8'h77, {32'hA5A58004 + 32'(8 * i), 32'hA5A58000 + 32'(8 * i)}, 2'd0, i == 7);
        end
        issue_ar(8'h77, 32'h8000, 8'd7, 3'd3, 2'd1, 3'd0);
        wait_beats_left(6);
        rst_n = 1'b0;
        exp_r.delete();
        exp_lite.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("arready_before_rise2", 64'(s_axi.arready), 64'd0);
        @(posedge clk);
        #1;
        check("arready_after_reset2", 64'(s_axi.arready), 64'd1);

        // Fresh burst after reset
        push_lite_run(32'h9000, 4);
        push_beat(8'h88, 64'hA5A59004_A5A59000, 2'd0, 1'b0);
        push_beat(8'h88, 64'hA5A5900C_A5A59008, 2'd0, 1'b1);
        issue_ar(8'h88, 32'h9000, 8'd1, 3'd3, 2'd1, 3'd0);
        wait_done("post_reset", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_axil_adapter_rd.md
# axi_axil_adapter_rd

Read-only AXI4 to AXI4-Lite bridge with data-width downsizing, full burst support (FIXED/INCR/WRAP) and a configurable number of outstanding AXI-Lite reads. It sits between an AXI4 master read channel and an AXI4-Lite register or peripheral fabric. It splits each AXI beat into one or more AXI-Lite reads, reassembles the returned words into AXI beats, and pipelines address issue ahead of data return to hide slave latency.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on both sides
- AXI_DATA_WIDTH, 64, AXI data width; power of two, 8 or more
- AXI_ID_WIDTH, 8, AXI ID width
- AXIL_DATA_WIDTH, 32, AXI-Lite data width; power of two, no larger than AXI_DATA_WIDTH
- MAX_OUTSTANDING, 4, maximum AXI-Lite reads in flight; power of two, 1 to 16

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- s_axi_arid / araddr / arlen / arsize / arburst / arprot  in  AXI_ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2 / 3  AXI read address
- s_axi_arvalid  in  1, s_axi_arready  out  1  AR handshake
- s_axi_rid / rdata / rresp / rlast  out  AXI_ID_WIDTH / AXI_DATA_WIDTH / 2 / 1  AXI read data
- s_axi_rvalid  out  1, s_axi_rready  in  1  R handshake
- m_axil_araddr / arprot  out  ADDR_WIDTH / 3  AXI-Lite read address
- m_axil_arvalid  out  1, m_axil_arready  in  1  AXI-Lite AR handshake
- m_axil_rdata / rresp  in  AXIL_DATA_WIDTH / 2  AXI-Lite read data
- m_axil_rvalid  in  1, m_axil_rready  out  1  AXI-Lite R handshake

## Operation
- Notation: W = AXIL_DATA_WIDTH/8 and B = AXI_DATA_WIDTH/8, both in bytes. S = 2^arsize; arsize values above log2(B) are clamped to log2(B).
- Segments per beat: N = max(1, S/W).
- The block handles one burst at a time. States:
  - IDLE: s_axi_arready=1. An AR handshake latches id, addr, len, size, burst and prot, and moves to BURST.
  - BURST: the issue and collect engines run. The block returns to IDLE on the R handshake that carries rlast=1.
- Beat addresses:
  - FIXED (0): every beat uses the start address.
  - INCR (1) and reserved (3): each beat adds S.
  - WRAP (2): the address wraps within a (arlen+1)*S aligned window; arlen is 1, 3, 7 or 15.
- Segment k (0 to N-1) of a beat is read at lite address align(beat_addr, max(S,W)) aligned down to W, plus k*W. m_axil_arprot is the latched arprot.
- Issue engine: m_axil_arvalid is asserted while segments remain and outstanding < MAX_OUTSTANDING. The outstanding counter increments on an AXI-Lite AR handshake and decrements on an AXI-Lite R handshake; both in the same cycle leaves it unchanged.
- Collect engine:
  - Each returned lite word is written into the beat buffer at byte lanes [(A_k mod B), (A_k mod B)+W).
  - Lanes not written in the current beat read as zero.
  - rresp is the numeric maximum of the segment responses for that beat.
  - After segment N-1 the beat moves to the output register: rid is the latched id, and rlast=1 on beat arlen.
- m_axil_rready = !s_axi_rvalid || s_axi_rready.
- Reset mid-burst discards all state. Both sides must be reset together; a lite response that arrives for a read issued before reset is a system error.

## Timing
- Reset values: s_axi_arready=0, s_axi_rvalid=0, s_axi_rlast=0, s_axi_rdata=0, s_axi_rresp=0, s_axi_rid=0, m_axil_arvalid=0, m_axil_araddr=0, m_axil_arprot=0, m_axil_rready=0, outstanding=0.
- s_axi_arready rises in the first cycle after rst_n goes high.
- AR handshake in cycle t: first m_axil_arvalid in cycle t+1.
- The final lite R handshake of a beat in cycle t gives s_axi_rvalid in cycle t+1 (registered).
- Sustained throughput is one lite read per cycle when MAX_OUTSTANDING exceeds the slave latency and neither side stalls.
- After rlast is accepted in cycle t, s_axi_arready=1 in cycle t+1.
- All valid signals stay asserted with stable payload until their handshake completes.

## Test plan
- 64-to-32 path, INCR, araddr=0x1000, arlen=3, arsize=3 -> lite reads at 0x1000, 0x1004 through 0x101C (8 reads). Four R beats with data {word1,word0} in order, rlast on beat 3, rid echoed.
- Narrow read, arsize=2, araddr=0x2004, arlen=1, INCR -> lite reads at 0x2004 then 0x2008. Beat 0 data in lanes 4-7 with lanes 0-3 zero; beat 1 data in lanes 0-3 with lanes 4-7 zero.
- WRAP, araddr=0x3018, arlen=3, arsize=3 -> beat addresses 0x3018, 0x3000, 0x3008, 0x3010. FIXED with arlen=2 -> three beats, all at the start address.
- Slave latency of 6 cycles, MAX_OUTSTANDING=4 -> m_axil_arvalid drops while 4 reads are in flight; the outstanding count never exceeds 4 and data stays in order.
- Second segment returns SLVERR (2) and the first returns OKAY -> beat rresp=2. DECERR (3) combined with SLVERR -> rresp=3.
- s_axi_rready held low for 10 cycles mid-burst, then rst_n pulsed low mid-burst -> no data lost or duplicated during the stall. After reset, all outputs match the reset values and a fresh burst completes correctly.
